edge_event_scheduler: RTL and testbench

Multi-channel edge-event controller that sits in front of the shared edge-detection/event path. It samples `N_CH` level inputs, detects edges per channel, and latches each one as a pending event. It then arbitrates pending events round-robin onto a single valid/ready event port consumed by downstream logic. Events that arrive while their channel already has one pending are dropped and counted.

---
 rtl/edge_event_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_edge_event_scheduler.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/edge_event_scheduler.sv
// Multi-channel edge-event scheduler: detects per-channel edges on level inputs,
// latches them as pending events and hands them out round-robin on a single
// valid/ready port. Edges on a channel that already has an event pending are
// dropped and counted in a saturating counter.
//
// Optional feature macro: EDGE_SCHED_BOTH_EN
//   defined   -> both edges detected, polarity stored per channel, shown on evt_pol
//   undefined -> rising edges only, evt_pol tied to 1
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   sig_in[N_CH]  level inputs (already synchronous to clk)
//   ch_en[N_CH]   per-channel enable
//   evt_valid/evt_ready/evt_ch/evt_pol  event handshake port
//   pending[N_CH] pending-event bitmap
//   drop_cnt      saturating count of dropped events
module edge_event_scheduler #(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned CH_W  = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  sig_in,
    input  logic [N_CH-1:0]  ch_en,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CH_W-1:0]  evt_ch,
    output logic             evt_pol,
    output logic [N_CH-1:0]  pending,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int unsigned NDROP_W = $clog2(N_CH + 1);
    localparam int unsigned SUM_W   = CNT_W + NDROP_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_OFFER = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [N_CH-1:0]   prev_q, prev_d;
    logic [N_CH-1:0]   pending_q, pending_d;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]   evt_ch_q, evt_ch_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic              hs;
    logic              do_grant;
    logic [CH_W-1:0]   ptr_next;
    logic [CH_W-1:0]   search_start;
    logic [CH_W-1:0]   gnt_idx;
    logic [N_CH-1:0]   gnt_mask;
    logic [N_CH-1:0]   edge_v;
    logic [N_CH-1:0]   edge_en;
    logic [N_CH-1:0]   held;
    logic [N_CH-1:0]   drop;
    logic [NDROP_W-1:0] n_drop;
    logic [SUM_W-1:0]  cnt_sum;

`ifdef EDGE_SCHED_BOTH_EN
    logic [N_CH-1:0]   pol_q, pol_d;
    logic              evt_pol_q, evt_pol_d;
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            prev_q     <= '0;
            pending_q  <= '0;
            rr_ptr_q   <= '0;
            evt_ch_q   <= '0;
            drop_cnt_q <= '0;
`ifdef EDGE_SCHED_BOTH_EN
            pol_q      <= '0;
            evt_pol_q  <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            pending_q  <= pending_d;
            rr_ptr_q   <= rr_ptr_d;
            evt_ch_q   <= evt_ch_d;
            drop_cnt_q <= drop_cnt_d;
`ifdef EDGE_SCHED_BOTH_EN
            pol_q      <= pol_d;
            evt_pol_q  <= evt_pol_d;
`endif
        end
    end

    // Round-robin arbiter: after a handshake the search restarts just past the
    // channel just served, so a same-cycle re-grant is already fair.
    always_comb begin : arb
        int unsigned j;
        logic        found;
        j            = 0;
        found        = 1'b0;
        hs           = (state_q == S_OFFER) && evt_ready;
        ptr_next     = (evt_ch_q == CH_W'(N_CH - 1)) ? '0 : evt_ch_q + CH_W'(1);
        search_start = (state_q == S_OFFER) ? ptr_next : rr_ptr_q;
        do_grant     = (|pending_q) && ((state_q == S_IDLE) || hs);
        gnt_idx      = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            j = 32'(search_start) + k;
            if (j >= N_CH) begin
                j = j - N_CH;
            end
            if (!found && pending_q[CH_W'(j)]) begin
                found   = 1'b1;
                gnt_idx = CH_W'(j);
            end
        end
        gnt_mask = '0;
        if (do_grant) begin
            gnt_mask[gnt_idx] = 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (|pending_q)            state_d = S_OFFER;
            S_OFFER: if (hs && !(|pending_q))   state_d = S_IDLE;
            default:                            state_d = S_IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        prev_d   = sig_in;
        rr_ptr_d = rr_ptr_q;
        evt_ch_d = evt_ch_q;
        if (hs) begin
            rr_ptr_d = ptr_next;
        end
        if (do_grant) begin
            evt_ch_d = gnt_idx;
        end

`ifdef EDGE_SCHED_BOTH_EN
        edge_v = sig_in ^ prev_q;
`else
        edge_v = sig_in & ~prev_q;
`endif
        edge_en = edge_v & ch_en;
        // Bits granted this cycle no longer count as occupied
        held      = pending_q & ~gnt_mask;
        drop      = edge_en & held;
        pending_d = (held | edge_en) & ch_en;

`ifdef EDGE_SCHED_BOTH_EN
        evt_pol_d = evt_pol_q;
        if (do_grant) begin
            evt_pol_d = pol_q[gnt_idx];
        end
        // Polarity captured only on a fresh event; a dropped edge keeps the original
        pol_d = pol_q;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (edge_en[i] && !held[i]) begin
                pol_d[i] = sig_in[i];
            end
        end
`endif

        n_drop = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            n_drop = n_drop + NDROP_W'(drop[i]);
        end
        cnt_sum    = SUM_W'(drop_cnt_q) + SUM_W'(n_drop);
        drop_cnt_d = (cnt_sum[SUM_W-1:CNT_W] != '0) ? CNT_MAX : cnt_sum[CNT_W-1:0];
    end

    assign evt_valid = (state_q == S_OFFER);
    assign evt_ch    = evt_ch_q;
    assign pending   = pending_q;
    assign drop_cnt  = drop_cnt_q;
`ifdef EDGE_SCHED_BOTH_EN
    assign evt_pol   = evt_pol_q;
`else
    assign evt_pol   = 1'b1;
`endif

endmodule

// File: tb/tb_edge_event_scheduler.sv
// Directed bench for edge_event_scheduler: a table of per-cycle
// {inputs, expected outputs} records plus a hand-written saturation sequence.
module tb_edge_event_scheduler;

    localparam int unsigned N_CH  = 4;
    localparam int unsigned CH_W  = 2;
    localparam int unsigned CNT_W = 8;

    logic             clk;
    logic             rst;
    logic [N_CH-1:0]  sig_in;
    logic [N_CH-1:0]  ch_en;
    logic             evt_valid;
    logic             evt_ready;
    logic [CH_W-1:0]  evt_ch;
    logic             evt_pol;
    logic [N_CH-1:0]  pending;
    logic [CNT_W-1:0] drop_cnt;

    int n_tests;
    int n_fail;

    typedef struct {
        logic             rst;
        logic [N_CH-1:0]  sig;
        logic [N_CH-1:0]  en;
        logic             rdy;
        logic             e_valid;
        logic [CH_W-1:0]  e_ch;
        logic             e_pol;
        logic [N_CH-1:0]  e_pend;
        logic [CNT_W-1:0] e_drop;
    } vec_t;

    vec_t vecs[$];

    edge_event_scheduler #(
        .N_CH (N_CH),
        .CH_W (CH_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sig_in   (sig_in),
        .ch_en    (ch_en),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_ch   (evt_ch),
        .evt_pol  (evt_pol),
        .pending  (pending),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic v, input logic [CH_W-1:0] ch,
                              input logic pol, input logic [N_CH-1:0] pend,
                              input logic [CNT_W-1:0] drp);
        check({tag, ".evt_valid"}, 32'(evt_valid), 32'(v));
        check({tag, ".evt_ch"},    32'(evt_ch),    32'(ch));
        check({tag, ".evt_pol"},   32'(evt_pol),   32'(pol));
        check({tag, ".pending"},   32'(pending),   32'(pend));
        check({tag, ".drop_cnt"},  32'(drop_cnt),  32'(drp));
    endtask

    task automatic add(input logic r, input logic [3:0] s, input logic [3:0] en, input logic rd,
                       input logic v, input logic [1:0] ch, input logic pol,
                       input logic [3:0] pend, input logic [7:0] drp);
        vec_t t;
        t.rst = r;  t.sig = s;  t.en = en;  t.rdy = rd;
        t.e_valid = v;  t.e_ch = ch;  t.e_pol = pol;  t.e_pend = pend;  t.e_drop = drp;
        vecs.push_back(t);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        sig_in    = '0;
        ch_en     = '1;
        evt_ready = 1'b0;

`ifdef EDGE_SCHED_BOTH_EN
        //   rst sig      en       rdy   valid ch pol pend     drop
        add(1, 4'b0000, 4'b1111, 1,    0, 0, 1, 4'b0000, 0);  // reset
        add(0, 4'b0001, 4'b1111, 1,    0, 0, 1, 4'b0001, 0);  // rise ch0
        add(0, 4'b0000, 4'b1111, 1,    1, 0, 1, 4'b0001, 0);  // fall re-pends with grant
        add(0, 4'b0000, 4'b1111, 1,    1, 0, 0, 4'b0000, 0);  // second event, falling
        add(0, 4'b0000, 4'b1111, 1,    0, 0, 0, 4'b0000, 0);
        add(0, 4'b0010, 4'b1111, 0,    0, 0, 0, 4'b0010, 0);  // rise ch1
        add(0, 4'b0010, 4'b1111, 0,    1, 1, 1, 4'b0000, 0);
        add(0, 4'b0011, 4'b1111, 0,    1, 1, 1, 4'b0001, 0);  // rise ch0 pending
        add(0, 4'b0010, 4'b1111, 0,    1, 1, 1, 4'b0001, 1);  // fall on pending rise: drop
        add(0, 4'b0010, 4'b1111, 1,    1, 0, 1, 4'b0000, 1);  // keeps rising polarity
`else
        //   rst sig      en       rdy   valid ch pol pend     drop
        add(1, 4'b0000, 4'b1111, 0,    0, 0, 1, 4'b0000, 0);  // reset
        add(0, 4'b0001, 4'b1111, 1,    0, 0, 1, 4'b0001, 0);  // edge t: pending
        add(0, 4'b0001, 4'b1111, 1,    1, 0, 1, 4'b0000, 0);  // t+1: offered
        add(0, 4'b0001, 4'b1111, 1,    0, 0, 1, 4'b0000, 0);  // t+2: accepted
        add(1, 4'b0000, 4'b1111, 0,    0, 0, 1, 4'b0000, 0);  // reset, rr_ptr=0
        add(0, 4'b1110, 4'b1111, 1,    0, 0, 1, 4'b1110, 0);  // ch3,2,1 together
        add(0, 4'b1110, 4'b1111, 1,    1, 1, 1, 4'b1100, 0);
        add(0, 4'b1110, 4'b1111, 1,    1, 2, 1, 4'b1000, 0);
        add(0, 4'b1110, 4'b1111, 1,    1, 3, 1, 4'b0000, 0);
        add(0, 4'b1110, 4'b1111, 1,    0, 3, 1, 4'b0000, 0);
        add(0, 4'b1010, 4'b1111, 0,    0, 3, 1, 4'b0000, 0);  // ch2 low
        add(0, 4'b1110, 4'b1111, 0,    0, 3, 1, 4'b0100, 0);  // ch2 rise
        add(0, 4'b1110, 4'b1111, 0,    1, 2, 1, 4'b0000, 0);  // ch2 offered, stalled
        add(0, 4'b1100, 4'b1111, 0,    1, 2, 1, 4'b0000, 0);
        add(0, 4'b1110, 4'b1111, 0,    1, 2, 1, 4'b0010, 0);  // ch1 rise while stalled
        add(0, 4'b1110, 4'b1111, 0,    1, 2, 1, 4'b0010, 0);
        add(0, 4'b1110, 4'b1111, 0,    1, 2, 1, 4'b0010, 0);
        add(0, 4'b1110, 4'b1111, 1,    1, 1, 1, 4'b0000, 0);  // ready: ch1 next
        add(0, 4'b1111, 4'b1111, 0,    1, 1, 1, 4'b0001, 0);  // ch0 edge 1
        add(0, 4'b1110, 4'b1111, 0,    1, 1, 1, 4'b0001, 0);
        add(0, 4'b1111, 4'b1111, 0,    1, 1, 1, 4'b0001, 1);  // ch0 edge 2: drop
        add(0, 4'b1110, 4'b1111, 0,    1, 1, 1, 4'b0001, 1);
        add(0, 4'b1111, 4'b1111, 0,    1, 1, 1, 4'b0001, 2);  // ch0 edge 3: drop
        add(0, 4'b1100, 4'b1111, 0,    1, 1, 1, 4'b0001, 2);
        add(0, 4'b1111, 4'b1111, 0,    1, 1, 1, 4'b0011, 3);  // offered ch1 edge not a drop
        add(0, 4'b1100, 4'b1111, 0,    1, 1, 1, 4'b0011, 3);
        add(0, 4'b1111, 4'b1111, 0,    1, 1, 1, 4'b0011, 5);  // two drops same cycle
        add(0, 4'b0111, 4'b0111, 0,    1, 1, 1, 4'b0011, 5);
        add(0, 4'b1111, 4'b0111, 0,    1, 1, 1, 4'b0011, 5);  // ch3 disabled: ignored
        add(0, 4'b1111, 4'b0110, 0,    1, 1, 1, 4'b0010, 5);  // disable ch0 clears pending
        add(1, 4'b1111, 4'b1111, 0,    0, 0, 1, 4'b0000, 0);  // reset mid-offer
        add(0, 4'b1111, 4'b1111, 0,    0, 0, 1, 4'b1111, 0);  // high after reset = rise
        add(0, 4'b1111, 4'b1111, 1,    1, 0, 1, 4'b1110, 0);
        add(0, 4'b1111, 4'b1111, 1,    1, 1, 1, 4'b1100, 0);
        add(0, 4'b1111, 4'b1111, 1,    1, 2, 1, 4'b1000, 0);
        add(0, 4'b1111, 4'b1111, 1,    1, 3, 1, 4'b0000, 0);
        add(0, 4'b1111, 4'b1111, 1,    0, 3, 1, 4'b0000, 0);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            rst       = vecs[i].rst;
            sig_in    = vecs[i].sig;
            ch_en     = vecs[i].en;
            evt_ready = vecs[i].rdy;
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_ch,
                       vecs[i].e_pol, vecs[i].e_pend, vecs[i].e_drop);
        end

`ifndef EDGE_SCHED_BOTH_EN
        // Saturation: ch1 held on the port, ch0 toggled repeatedly
        rst = 1'b1; sig_in = '0; ch_en = '1; evt_ready = 1'b0;
        tick();
        rst = 1'b0; sig_in = 4'b0010;
        tick();
        tick();
        check_outs("sat_setup", 1'b1, 2'd1, 1'b1, 4'b0000, 8'd0);
        for (int k = 0; k < 300; k++) begin
            sig_in = 4'b0011;
            tick();
            sig_in = 4'b0010;
            tick();
            if (k == 9) begin
                check_outs("sat_mid", 1'b1, 2'd1, 1'b1, 4'b0001, 8'd9);
            end
        end
        check_outs("sat_end", 1'b1, 2'd1, 1'b1, 4'b0001, 8'd255);
        evt_ready = 1'b1;
        tick();
        check_outs("sat_release", 1'b1, 2'd0, 1'b1, 4'b0000, 8'd255);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
